// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment floor reader: segment patterns
// (bit6=g .. bit0=a) and the reader state encoding.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        LOCKED = 2'd2,
        ERROR  = 2'd3
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_D0    = 7'b0111111;
    localparam logic [6:0] SEG_D1    = 7'b0000110;
    localparam logic [6:0] SEG_D2    = 7'b1011011;
    localparam logic [6:0] SEG_D3    = 7'b1001111;
    localparam logic [6:0] SEG_D4    = 7'b1100110;
    localparam logic [6:0] SEG_D5    = 7'b1101101;
    localparam logic [6:0] SEG_D6    = 7'b1111101;
    localparam logic [6:0] SEG_D7    = 7'b0000111;

    localparam int CNT_W = 8;

endpackage

// File: rtl/seg7_pattern_match.sv
// Combinational classifier: segment pattern -> legal digit / blank / illegal.
module seg7_pattern_match
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       is_digit,
    output logic       is_blank,
    output logic [2:0] digit
);

    always_comb begin
        is_digit = 1'b1;
        is_blank = 1'b0;
        digit    = 3'd0;
        case (pattern)
            SEG_D0:    digit = 3'd0;
            SEG_D1:    digit = 3'd1;
            SEG_D2:    digit = 3'd2;
            SEG_D3:    digit = 3'd3;
            SEG_D4:    digit = 3'd4;
            SEG_D5:    digit = 3'd5;
            SEG_D6:    digit = 3'd6;
            SEG_D7:    digit = 3'd7;
            SEG_BLANK: begin
                is_digit = 1'b0;
                is_blank = 1'b1;
            end
            default:   is_digit = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_floor_reader.sv
// Debounced seven-segment floor indicator reader.
// Optional saturating error-entry counter enabled by macro SEG7_ERR_COUNT_EN.
module seg7_floor_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    output logic [2:0] floor_out,
    output logic       floor_valid,
    output logic       floor_change,
    output logic       blank,
    output logic       code_err
`ifdef SEG7_ERR_COUNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam logic [CNT_W:0] STABLE_W = (CNT_W+1)'(STABLE_CYCLES);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [6:0]       sync_p0;
    logic [6:0]       sample;
    logic [6:0]       prev;
    logic [CNT_W-1:0] cnt, cnt_next;
    state_t           state, state_next;
    logic [2:0]       floor_out_next;
    logic             valid_next, change_next, blank_next, err_next;
    logic             have_digit, have_digit_next;
    logic             is_digit, is_blank;
    logic [2:0]       digit;
    logic             changed;
`ifdef SEG7_ERR_COUNT_EN
    logic [7:0]       err_count_next;
`endif

    seg7_pattern_match u_match (
        .pattern  (sample),
        .is_digit (is_digit),
        .is_blank (is_blank),
        .digit    (digit)
    );

    assign changed = (sample != prev);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0      <= '0;
            sample       <= '0;
            prev         <= '0;
            cnt          <= '0;
            state        <= IDLE;
            floor_out    <= 3'd0;
            floor_valid  <= 1'b0;
            floor_change <= 1'b0;
            blank        <= 1'b0;
            code_err     <= 1'b0;
            have_digit   <= 1'b0;
`ifdef SEG7_ERR_COUNT_EN
            err_count    <= 8'd0;
`endif
        end else begin
            sync_p0      <= seg_in;
            sample       <= sync_p0;
            prev         <= sample;
            cnt          <= cnt_next;
            state        <= state_next;
            floor_out    <= floor_out_next;
            floor_valid  <= valid_next;
            floor_change <= change_next;
            blank        <= blank_next;
            code_err     <= err_next;
            have_digit   <= have_digit_next;
`ifdef SEG7_ERR_COUNT_EN
            err_count    <= err_count_next;
`endif
        end
    end

    // cnt counts repeats after the first sample of a run, so a run of
    // STABLE_CYCLES identical samples completes when cnt+2 reaches it.
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        floor_out_next  = floor_out;
        valid_next      = floor_valid;
        change_next     = 1'b0;
        blank_next      = blank;
        err_next        = code_err;
        have_digit_next = have_digit;
`ifdef SEG7_ERR_COUNT_EN
        err_count_next  = err_count;
`endif
        if (changed) begin
            state_next = SETTLE;
            cnt_next   = '0;
            valid_next = 1'b0;
            blank_next = 1'b0;
            err_next   = 1'b0;
        end else if (state == SETTLE) begin
            if (({1'b0, cnt} + (CNT_W+1)'(2)) >= STABLE_W) begin
                if (is_digit) begin
                    state_next      = LOCKED;
                    floor_out_next  = digit;
                    valid_next      = 1'b1;
                    change_next     = !have_digit || (digit != floor_out);
                    have_digit_next = 1'b1;
                end else if (is_blank) begin
                    state_next      = IDLE;
                    blank_next      = 1'b1;
                    have_digit_next = 1'b0;
                end else begin
                    state_next      = ERROR;
                    err_next        = 1'b1;
`ifdef SEG7_ERR_COUNT_EN
                    err_count_next  = sat_inc(err_count);
`endif
                end
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end
    end

`ifndef SEG7_ERR_COUNT_EN
    // Keeps the helper referenced when the counter is compiled out.
    logic [7:0] sat_unused;
    assign sat_unused = sat_inc(8'd0);
`endif

endmodule

// File: tb/tb_seg7_floor_reader.sv
// Directed self-checking bench for seg7_floor_reader (STABLE_CYCLES = 4).
module tb_seg7_floor_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg_in;
    logic [2:0] floor_out;
    logic       floor_valid;
    logic       floor_change;
    logic       blank;
    logic       code_err;
`ifdef SEG7_ERR_COUNT_EN
    logic [7:0] err_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seg7_floor_reader #(.STABLE_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .seg_in       (seg_in),
        .floor_out    (floor_out),
        .floor_valid  (floor_valid),
        .floor_change (floor_change),
        .blank        (blank),
        .code_err     (code_err)
`ifdef SEG7_ERR_COUNT_EN
        ,
        .err_count    (err_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges; returns 1 time unit after the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic saw_pulse;
        rst    = 1'b1;
        seg_in = 7'b0000000;
        step(2);
        chk("rst_floor_out", 32'(floor_out), 0);
        chk("rst_valid", 32'(floor_valid), 0);
        chk("rst_change", 32'(floor_change), 0);
        chk("rst_blank", 32'(blank), 0);
        chk("rst_code_err", 32'(code_err), 0);
`ifdef SEG7_ERR_COUNT_EN
        chk("rst_err_count", 32'(err_count), 0);
`endif
        rst = 1'b0;

        // digit 2: accepted at edge 6
        seg_in = 7'b1011011;
        step(5);
        chk("d2_edge5_valid", 32'(floor_valid), 0);
        step(1);
        chk("d2_edge6_out", 32'(floor_out), 2);
        chk("d2_edge6_valid", 32'(floor_valid), 1);
        chk("d2_edge6_change", 32'(floor_change), 1);
        step(1);
        chk("d2_edge7_change", 32'(floor_change), 0);
        chk("d2_edge7_valid", 32'(floor_valid), 1);

        // digit 3
        seg_in = 7'b1001111;
        step(6);
        chk("d3_out", 32'(floor_out), 3);
        chk("d3_change", 32'(floor_change), 1);
        step(1);

        // two-cycle glitch to 1, then back to 3
        seg_in = 7'b0000110;
        step(2);
        chk("glitch_edge2_valid", 32'(floor_valid), 1);
        seg_in = 7'b1001111;
        saw_pulse = 1'b0;
        step(1);
        chk("glitch_edge3_valid", 32'(floor_valid), 0);
        chk("glitch_edge3_out", 32'(floor_out), 3);
        for (int i = 4; i <= 7; i++) begin
            saw_pulse = saw_pulse | floor_change;
            step(1);
        end
        chk("glitch_edge7_valid", 32'(floor_valid), 0);
        step(1);
        chk("glitch_edge8_valid", 32'(floor_valid), 1);
        chk("glitch_edge8_out", 32'(floor_out), 3);
        saw_pulse = saw_pulse | floor_change;
        step(1);
        saw_pulse = saw_pulse | floor_change;
        chk("glitch_no_change", 32'(saw_pulse), 0);

        // lock 5, blank, then 5 again
        seg_in = 7'b1101101;
        step(6);
        chk("d5_out", 32'(floor_out), 5);
        chk("d5_change", 32'(floor_change), 1);
        seg_in = 7'b0000000;
        step(6);
        chk("blank_blank", 32'(blank), 1);
        chk("blank_valid", 32'(floor_valid), 0);
        chk("blank_out_hold", 32'(floor_out), 5);
        seg_in = 7'b1101101;
        step(5);
        chk("reblank_edge5_blank", 32'(blank), 0);
        step(1);
        chk("re5_out", 32'(floor_out), 5);
        chk("re5_valid", 32'(floor_valid), 1);
        chk("re5_change", 32'(floor_change), 1);

        // illegal pattern
        seg_in = 7'b1111111;
        step(5);
        chk("err_edge5_code_err", 32'(code_err), 0);
        step(1);
        chk("err_code_err", 32'(code_err), 1);
        chk("err_valid", 32'(floor_valid), 0);
        chk("err_out_hold", 32'(floor_out), 5);
`ifdef SEG7_ERR_COUNT_EN
        chk("err_count_1", 32'(err_count), 1);
`endif
        for (int i = 0; i < 300; i++) begin
            seg_in = (i % 2 == 0) ? 7'b1111110 : 7'b1111111;
            step(6);
        end
        chk("err_many_code_err", 32'(code_err), 1);
`ifdef SEG7_ERR_COUNT_EN
        chk("err_count_sat", 32'(err_count), 255);
`endif
        seg_in = 7'b0000000;
        step(3);
        chk("err_cleared_on_change", 32'(code_err), 0);
        step(3);

        // reset mid-SETTLE
        seg_in = 7'b1111101;
        step(3);
        rst = 1'b1;
        #2;
        chk("midrst_out", 32'(floor_out), 0);
        chk("midrst_valid", 32'(floor_valid), 0);
        chk("midrst_blank", 32'(blank), 0);
        chk("midrst_code_err", 32'(code_err), 0);
`ifdef SEG7_ERR_COUNT_EN
        chk("midrst_err_count", 32'(err_count), 0);
`endif
        step(1);
        rst = 1'b0;
        step(5);
        chk("postrst_edge5_valid", 32'(floor_valid), 0);
        step(1);
        chk("postrst_out", 32'(floor_out), 6);
        chk("postrst_valid", 32'(floor_valid), 1);
        chk("postrst_change", 32'(floor_change), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_floor_reader.md
SEG7_FLOOR_READER -- requirements
Module: seg7_floor_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: consecutive identical synchronized samples required to accept a pattern; legal range 1..255.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port seg_in  input  7  segment lines g..a (bit6=g, bit0=a), active-high, asynchronous to clk.
REQ-005 SHALL have port floor_out  output  3  last accepted floor number, binary 0..7.
REQ-006 SHALL have port floor_valid  output  1  high while the accepted pattern is a legal digit and still present.
REQ-007 SHALL have port floor_change  output  1  one-cycle pulse when a newly accepted digit differs from the previous accepted digit.
REQ-008 SHALL have port blank  output  1  high while the accepted pattern is all-off (7'b0000000).
REQ-009 SHALL have port code_err  output  1  high while the accepted pattern is neither a digit nor blank.
REQ-010 SHALL have port err_count  output  8  saturating count of ERROR entries (present only with SEG7_ERR_COUNT_EN).

Function
REQ-011 SHALL pass seg_in through a 2-flop synchronizer; all decisions use the second flop (sample).
REQ-012 SHALL map patterns: 0111111->0, 0000110->1, 1011011->2, 1001111->3, 1100110->4, 1101101->5, 1111101->6, 0000111->7; all other non-zero patterns are illegal.
REQ-013 SHALL implement states IDLE, SETTLE, LOCKED, ERROR; reset state IDLE.
REQ-014 SHALL, in any state, enter SETTLE and clear the stability counter when sample differs from the previous sample.
REQ-015 SHALL, in SETTLE, increment the counter each cycle sample is unchanged; on reaching STABLE_CYCLES: digit -> LOCKED, blank -> IDLE, illegal -> ERROR.
REQ-016 SHALL update outputs so a new pattern held on seg_in is reflected exactly 2+STABLE_CYCLES rising edges after the first edge that samples it.
REQ-017 SHALL, on entering LOCKED, load floor_out, set floor_valid; pulse floor_change for one cycle if the digit differs from the previous locked digit or no digit has been locked since reset or since the last blank.
REQ-018 SHALL deassert floor_valid, blank and code_err on entering SETTLE; floor_out holds its last value through SETTLE, IDLE and ERROR.
REQ-019 SHALL, in IDLE after acceptance of blank, assert blank and keep floor_valid low.
REQ-020 SHALL, in ERROR, assert code_err, keep floor_valid low, and hold until sample changes.
REQ-021 SHALL treat a pattern change on the same cycle the counter would reach STABLE_CYCLES as a change (restart SETTLE, no acceptance).
REQ-022 SHALL never pulse floor_change for a re-accepted identical digit after a glitch shorter than STABLE_CYCLES.

Reset
REQ-023 SHALL, on rst high, asynchronously clear synchronizer, previous sample, counter, floor_out=0, floor_valid=0, floor_change=0, blank=0, code_err=0, err_count=0, state IDLE.
REQ-024 SHALL abandon any SETTLE in progress on reset; first acceptance afterwards produces floor_change per REQ-017.

Configuration
REQ-025 SHALL, with macro SEG7_ERR_COUNT_EN defined, include err_count incrementing by 1 on each ERROR entry, saturating at 255, cleared only by reset.
REQ-026 SHALL, without SEG7_ERR_COUNT_EN, omit the err_count port and its register; all other behaviour identical.

Structure
REQ-027 SHALL place the eight digit pattern constants, the blank constant and the state encoding in shared package seg7_pkg.
REQ-028 SHALL use one sub-module, seg7_pattern_match: combinational sample -> {is_digit, is_blank, digit[2:0]}.

Verification
REQ-029 SHALL cover: reset, seg_in=1011011 held -> at edge 6 (STABLE_CYCLES=4) floor_out=2, floor_valid=1, floor_change one-cycle pulse.
REQ-030 SHALL cover: locked on 3, seg_in glitches to 0000110 for 2 cycles then back -> floor_out stays 3, no floor_change, floor_valid low during glitch only.
REQ-031 SHALL cover: seg_in=1111111 held -> code_err=1, floor_valid=0, err_count=1; repeat 300 entries -> err_count=255.
REQ-032 SHALL cover: locked on 5, seg_in=0000000 held then 1101101 -> blank=1, then floor_out=5 with floor_change pulse.
REQ-033 SHALL cover: rst asserted mid-SETTLE -> all outputs zero immediately, no acceptance until 2+STABLE_CYCLES edges after release.
